// File: rtl/l1inval_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l1inval_pkg: shared constants for the CPX invalidation transmitter   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package l1inval_pkg;

  localparam int CPX_W = 145;
  localparam int VEC_W = 112;
  localparam int SEL_W = 2;
  localparam int RTN_W = 4;
  localparam int PAD_W = CPX_W - 1 - RTN_W - SEL_W - VEC_W;

  localparam logic [RTN_W-1:0] RTNTYP_EVICT = 4'b0011;

  // Bits {0,1,4,5,32,35,56,57,60,61,88,91}
  localparam logic [VEC_W-1:0] HIT0_MASK = 112'h0000_0900_0000_3300_0009_0000_0033;
  // Bits {0,4,32,35,56,60,88,91}
  localparam logic [VEC_W-1:0] HIT1_MASK = 112'h0000_0900_0000_1100_0009_0000_0011;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOOKUP = 3'd1;
  localparam state_t ST_SEND0  = 3'd2;
  localparam state_t ST_SEND1  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/l1inval_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l1inval_tx_if: request, directory and CPX signals of the transmitter |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface l1inval_tx_if;
  import l1inval_pkg::*;

  logic             dir_ready;
  logic             req;
  logic [39:0]      address;
  logic             ifill;
  logic [VEC_W-1:0] inval_vect0;
  logic [VEC_W-1:0] inval_vect1;
  logic             busy;
  logic             done;
  logic [CPX_W-1:0] cpx_pkt;
  logic             cpx_valid;
  logic             cpx_ready;

  // Bridge / directory / CPX side
  modport master (
    output dir_ready, req, address, ifill, inval_vect0, inval_vect1, cpx_ready,
    input  busy, done, cpx_pkt, cpx_valid
  );

  // Transmitter side
  modport slave (
    input  dir_ready, req, address, ifill, inval_vect0, inval_vect1, cpx_ready,
    output busy, done, cpx_pkt, cpx_valid
  );

endinterface
`default_nettype wire

// File: rtl/l1inval_tx_cpx_evict_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpx_evict_fmt: builds a CPX eviction packet from vector + line select|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cpx_evict_fmt
  import l1inval_pkg::*;
(
  input  logic [VEC_W-1:0] vect_i,
  input  logic [SEL_W-1:0] line_sel_i,
  output logic [CPX_W-1:0] pkt_o
);

  assign pkt_o = {1'b1, RTNTYP_EVICT, {PAD_W{1'b0}}, line_sel_i, vect_i};

endmodule
`default_nettype wire

// File: rtl/l1inval_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l1inval_tx: serialises L1 directory invalidation vectors into CPX    |
// | eviction packets. Revision: 1.0                                      |
// +----------------------------------------------------------------------+
module l1inval_tx
  import l1inval_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  l1inval_tx_if.slave  bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] addr_sel_q;
  logic             ifill_q;
  logic [VEC_W-1:0] vect0_q;
  logic [VEC_W-1:0] vect1_q;
  logic             any0_q;
  logic             any1_q;

  logic             accept;
  logic             any0;
  logic             any1;
  logic             send;
  logic             handshake;
  logic [VEC_W-1:0] fmt_vect;
  logic [SEL_W-1:0] fmt_sel;
  logic [CPX_W-1:0] fmt_pkt;

  assign accept    = bus.req && bus.dir_ready && (state_q == ST_IDLE);
  // Hit detection looks at the live directory outputs; only meaningful in LOOKUP
  assign any0      = |(bus.inval_vect0 & HIT0_MASK);
  assign any1      = ifill_q && (|(bus.inval_vect1 & HIT1_MASK));
  assign send      = (state_q == ST_SEND0) || (state_q == ST_SEND1);
  assign handshake = send && bus.cpx_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (any0)      state_d = ST_SEND0;
        else if (any1) state_d = ST_SEND1;
        else           state_d = ST_DONE;
      end
      ST_SEND0:  if (handshake) state_d = any1_q ? ST_SEND1 : ST_DONE;
      ST_SEND1:  if (handshake) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_sel_q <= '0;
      ifill_q    <= 1'b0;
      vect0_q    <= '0;
      vect1_q    <= '0;
      any0_q     <= 1'b0;
      any1_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_sel_q <= bus.address[5:4];
        ifill_q    <= bus.ifill;
      end
      if (state_q == ST_LOOKUP) begin
        vect0_q <= bus.inval_vect0;
        vect1_q <= bus.inval_vect1;
        any0_q  <= any0;
        any1_q  <= any1;
      end
    end
  end

  // Packet 1 always targets the odd line of the pair
  assign fmt_vect = (state_q == ST_SEND1) ? vect1_q : vect0_q;
  assign fmt_sel  = (state_q == ST_SEND1) ? {addr_sel_q[1], 1'b1} : addr_sel_q;

  cpx_evict_fmt u_fmt (
    .vect_i     (fmt_vect),
    .line_sel_i (fmt_sel),
    .pkt_o      (fmt_pkt)
  );

  assign bus.cpx_valid = send;
  assign bus.cpx_pkt   = send ? fmt_pkt : '0;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_l1inval_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_l1inval_tx: directed vector bench for the invalidation transmitter|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_l1inval_tx;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  l1inval_tx_if bus();

  l1inval_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ifill;
    logic [39:0]  addr;
    logic [111:0] v0;
    logic [111:0] v1;
    int           npkt;
    logic [1:0]   sel0;
    logic [111:0] pv0;
    logic [1:0]   sel1;
    logic [111:0] pv1;
  } vec_t;

  localparam int NV = 8;
  vec_t vt [NV];

  function automatic logic [144:0] mkpkt(input logic [1:0] sel, input logic [111:0] v);
    return {1'b1, 4'b0011, 26'd0, sel, v};
  endfunction

  task automatic chk(input string nm, input logic [144:0] act, input logic [144:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drives req in cycle T with junk vectors, then real vectors in T+1.
  // Returns at the falling edge inside T+1.
  task automatic issue_req(input logic ifl, input logic [39:0] a,
                           input logic [111:0] v0, input logic [111:0] v1);
    @(negedge clk);
    bus.req         = 1'b1;
    bus.address     = a;
    bus.ifill       = ifl;
    bus.inval_vect0 = {112{1'b1}};
    bus.inval_vect1 = {112{1'b1}};
    @(negedge clk);
    bus.req         = 1'b0;
    bus.address     = ~a;
    bus.ifill       = ~ifl;
    bus.inval_vect0 = v0;
    bus.inval_vect1 = v1;
  endtask

  task automatic run_vec(input int i);
    logic [144:0] ep;
    issue_req(vt[i].ifill, vt[i].addr, vt[i].v0, vt[i].v1);
    chk($sformatf("v%0d busy_lookup", i), {144'd0, bus.busy}, 145'd1);
    chk($sformatf("v%0d valid_lookup", i), {144'd0, bus.cpx_valid}, 145'd0);
    for (int k = 0; k <= vt[i].npkt + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.inval_vect0 = {112{1'b1}};
        bus.inval_vect1 = {112{1'b1}};
      end
      if (k < vt[i].npkt) begin
        ep = (k == 0) ? mkpkt(vt[i].sel0, vt[i].pv0) : mkpkt(vt[i].sel1, vt[i].pv1);
        chk($sformatf("v%0d pkt%0d", i, k), bus.cpx_pkt, ep);
        chk($sformatf("v%0d valid%0d", i, k), {144'd0, bus.cpx_valid}, 145'd1);
        chk($sformatf("v%0d done_early%0d", i, k), {144'd0, bus.done}, 145'd0);
      end else if (k == vt[i].npkt) begin
        chk($sformatf("v%0d done", i), {144'd0, bus.done}, 145'd1);
        chk($sformatf("v%0d valid_at_done", i), {144'd0, bus.cpx_valid}, 145'd0);
        chk($sformatf("v%0d pkt_at_done", i), bus.cpx_pkt, 145'd0);
        chk($sformatf("v%0d busy_at_done", i), {144'd0, bus.busy}, 145'd1);
      end else begin
        chk($sformatf("v%0d busy_after", i), {144'd0, bus.busy}, 145'd0);
        chk($sformatf("v%0d done_after", i), {144'd0, bus.done}, 145'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs;
    logic [144:0] ep;

    vt[0] = '{1'b0, 40'h0,  112'd0, 112'd0, 0, 2'b00, 112'd0, 2'b00, 112'd0};
    vt[1] = '{1'b0, 40'h20, 112'd1, 112'd0, 1, 2'b10, 112'd1, 2'b00, 112'd0};
    vt[2] = '{1'b1, 40'h20, 112'd1 << 57, 112'd1 << 4, 2,
              2'b10, 112'd1 << 57, 2'b11, 112'd1 << 4};
    vt[3] = '{1'b0, 40'h30, (112'd1 << 2) | (112'd1 << 3), 112'd1, 0,
              2'b00, 112'd0, 2'b00, 112'd0};
    vt[4] = '{1'b1, 40'h10, 112'd0, 112'd1 << 91, 1,
              2'b01, 112'd1 << 91, 2'b00, 112'd0};
    vt[5] = '{1'b1, 40'h30, (112'd1 << 61) | (112'd1 << 100), 112'd1 << 1, 1,
              2'b11, (112'd1 << 61) | (112'd1 << 100), 2'b00, 112'd0};
    vt[6] = '{1'b0, 40'hFF_FFFF_FFC0, 112'd1 << 35, {112{1'b1}}, 1,
              2'b00, 112'd1 << 35, 2'b00, 112'd0};
    vt[7] = '{1'b1, 40'h0, 112'd1 << 88, 112'd1 << 60, 2,
              2'b00, 112'd1 << 88, 2'b01, 112'd1 << 60};

    reset           = 1'b0;
    bus.dir_ready   = 1'b0;
    bus.req         = 1'b0;
    bus.address     = '0;
    bus.ifill       = 1'b0;
    bus.inval_vect0 = '0;
    bus.inval_vect1 = '0;
    bus.cpx_ready   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst busy",  {144'd0, bus.busy},      145'd0);
    chk("rst done",  {144'd0, bus.done},      145'd0);
    chk("rst valid", {144'd0, bus.cpx_valid}, 145'd0);
    chk("rst pkt",   bus.cpx_pkt,             145'd0);
    reset = 1'b1;

    // req while directory not ready is dropped
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("notready busy%0d", k), {144'd0, bus.busy}, 145'd0);
      chk($sformatf("notready valid%0d", k), {144'd0, bus.cpx_valid}, 145'd0);
      @(negedge clk);
    end
    bus.dir_ready = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: three stalled cycles on each packet of vector 2
    issue_req(vt[2].ifill, vt[2].addr, vt[2].v0, vt[2].v1);
    hs = 0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.inval_vect0 = {112{1'b1}};
        bus.inval_vect1 = {112{1'b1}};
      end
      bus.cpx_ready = (k == 3 || k == 7);
      if (k <= 7) begin
        ep = (k <= 3) ? mkpkt(vt[2].sel0, vt[2].pv0) : mkpkt(vt[2].sel1, vt[2].pv1);
        chk($sformatf("stall pkt c%0d", k + 2), bus.cpx_pkt, ep);
        chk($sformatf("stall valid c%0d", k + 2), {144'd0, bus.cpx_valid}, 145'd1);
      end
      chk($sformatf("stall done c%0d", k + 2), {144'd0, bus.done}, (k == 8) ? 145'd1 : 145'd0);
      if (bus.cpx_valid && bus.cpx_ready) hs++;
    end
    chk("stall handshakes", 145'(hs), 145'd2);
    bus.cpx_ready = 1'b1;

    // Asynchronous reset while stalled in SEND0
    bus.cpx_ready = 1'b0;
    issue_req(vt[1].ifill, vt[1].addr, vt[1].v0, vt[1].v1);
    @(negedge clk);
    chk("rstmid valid_before", {144'd0, bus.cpx_valid}, 145'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid valid", {144'd0, bus.cpx_valid}, 145'd0);
    chk("rstmid busy",  {144'd0, bus.busy},      145'd0);
    chk("rstmid pkt",   bus.cpx_pkt,             145'd0);
    @(posedge clk);
    #1;
    chk("rstmid done",  {144'd0, bus.done},      145'd0);
    @(negedge clk);
    reset         = 1'b1;
    bus.cpx_ready = 1'b1;
    run_vec(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l1inval_tx.md
# l1inval_tx

Invalidation-packet transmitter on the CPX side of the os2wb bridge: consumes the L1 directory's invalidation vectors one cycle after a directory lookup strobe and serialises them into 145-bit CPX eviction packets toward the cores. It is the sending end of the directory's `inval_vect0`/`inval_vect1` interface. The bridge's main FSM issues the lookup and waits on `done` before returning the data packet.

## Interface

Parameters: none (constants live in `l1inval_pkg`).

Ports:
- `clk`  in  1  bridge clock
- `reset`  in  1  asynchronous, active-low reset
- `dir_ready`  in  1  directory init done; `req` ignored while low
- `req`  in  1  one-cycle pulse, same cycle as the directory strobe
- `address`  in  40  request physical address, sampled on accepted `req`
- `ifill`  in  1  request is an ifill (second vector may be used), sampled on accepted `req`
- `inval_vect0`  in  112  directory vector, valid the cycle after `req`
- `inval_vect1`  in  112  directory second-line vector, valid the cycle after `req`
- `busy`  out  1  high from accepted `req` until `done`
- `done`  out  1  one-cycle pulse: all packets for this request sent (or none needed)
- `cpx_pkt`  out  145  CPX packet
- `cpx_valid`  out  1  packet valid
- `cpx_ready`  in  1  CPX accepts packet when `cpx_valid && cpx_ready`

## Operation

- Accept: `req && dir_ready && !busy`. A `req` while busy or not ready is dropped (bridge guarantees none).
- Hit masks: `HIT0` = bits {0,1,4,5,32,35,56,57,60,61,88,91}; `HIT1` = bits {0,4,32,35,56,60,88,91}. `any0 = |(inval_vect0 & HIT0)`, `any1 = ifill_q && |(inval_vect1 & HIT1)`.
- FSM states: IDLE, LOOKUP, SEND0, SEND1, DONE.
  - IDLE -> LOOKUP on accept; latch `address`, `ifill`.
  - LOOKUP (one cycle): register both vectors, `any0`, `any1`. -> SEND0 if `any0`, else SEND1 if `any1`, else DONE.
  - SEND0: drive packet 0; on handshake -> SEND1 if `any1`, else DONE.
  - SEND1: drive packet 1; on handshake -> DONE.
  - DONE: pulse `done`, -> IDLE.
- Packet format: [144]=1, [143:140]=`RTNTYP_EVICT` (4'b0011), [139:114]=0, [113:112]=line select, [111:0]=vector. Packet 0 line select = `address[5:4]`; packet 1 = `{address[5],1'b1}`.
- `cpx_pkt` is held stable while `cpx_valid && !cpx_ready`; it is 0 when `cpx_valid` is low.

## Timing

- Reset values: state IDLE; `busy`=0, `done`=0, `cpx_valid`=0, `cpx_pkt`=0; latched fields 0.
- `req` at cycle T -> LOOKUP at T+1 (vectors sampled at end of T+1) -> first `cpx_valid` at T+2.
- No hits: `done` at T+2, `busy` low at T+3.
- One packet, `cpx_ready` held high: `cpx_valid` T+2, `done` T+3.
- Two packets, `cpx_ready` high: packets T+2 and T+3 back to back, `done` T+4.
- Backpressure: each stalled cycle extends the state by one; no packet dropped or duplicated.
- `cpx_valid` never deasserts without handshake except on reset.
- Reset asserted mid-operation: immediate return to reset values; in-flight packet abandoned, no `done`.
- `ifill`=0: `inval_vect1` ignored regardless of contents.

## Structure

- `l1inval_pkg`: `CPX_W`=145, `RTNTYP_EVICT`, `HIT0_MASK`/`HIT1_MASK` (112-bit), FSM state enum.
- One sub-module: `cpx_evict_fmt` (combinational: vector + line select -> 145-bit packet), instantiated once and muxed by state.

## Test plan

- Reset then `req` at `address`=40'h0, directory vectors all zero -> no `cpx_valid`; `done` at T+2.
- `inval_vect0` bit0 set, `address[5:4]`=2'b10, `cpx_ready`=1 -> one packet at T+2, [143:140]=4'b0011, [113:112]=2'b10, [111:0]=vector; `done` T+3.
- `ifill`=1, vect0 bit 57 and vect1 bit 4 set, `address[5]`=1 -> packets at T+2 ([113:112]=2'b10) and T+3 ([113:112]=2'b11); `done` T+4.
- Same as previous with `cpx_ready` low for 3 cycles at each packet -> `cpx_pkt` stable while stalled, exactly two handshakes, `done` at T+10.
- `ifill`=0, vect1 bit 0 set, vect0 only wayval bits (2, 3) set -> no packets, `done` T+2.
- Reset asserted while in SEND0 with `cpx_ready` low -> `cpx_valid`, `busy` go 0 asynchronously; after release, new `req` is accepted.
